// File: rtl/vend_purchase_sequencer.sv
// vend_purchase_sequencer: customer-side card/keypad/payment/door sequencer for the vending machine
// Ports: CLK/RESET_N (async active-low); START, ITEM, LOAD_BAL, BAL_IN from the panel;
// VEND, INVALID_SEL, FAILED_TRAN, COST from the machine; CARD_IN, KEY_PRESS, ITEM_CODE,
// VALID_TRAN, DOOR_OPEN to the machine; BUSY, DONE, RESULT, BALANCE status.
// Define VEND_SEQ_BALANCE_EN to enable the card balance (load, PAY check, VEND decrement).
module vend_purchase_sequencer #(
  parameter int KEY_GAP      = 2,
  parameter int DOOR_HOLD    = 2,
  parameter int RESP_TIMEOUT = 16,
  parameter int BAL_W        = 8
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic [4:0]       ITEM,
  input  logic             LOAD_BAL,
  input  logic [BAL_W-1:0] BAL_IN,
  input  logic             VEND,
  input  logic             INVALID_SEL,
  input  logic             FAILED_TRAN,
  input  logic [2:0]       COST,
  output logic             CARD_IN,
  output logic             KEY_PRESS,
  output logic             VALID_TRAN,
  output logic             DOOR_OPEN,
  output logic [3:0]       ITEM_CODE,
  output logic             BUSY,
  output logic             DONE,
  output logic [1:0]       RESULT,
  output logic [BAL_W-1:0] BALANCE
);
`ifdef VEND_SEQ_BALANCE_EN
  localparam bit BAL_EN = 1'b1;
`else
  localparam bit BAL_EN = 1'b0;
`endif
  localparam int CW = $clog2(RESP_TIMEOUT + 8);
  typedef enum logic [3:0] {IDLE, CARD, KEY1, HOLD1, KEY2, HOLD2, WAIT_COST, PAY, WAIT_VEND, DOOR, FINISH} state_t;
  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [3:0]       ones_q;
  logic [1:0]       tens_q;
  logic [2:0]       cost_q;
  logic             declined_q;
  logic             card_q, key_q, vt_q, door_q, busy_q, done_q;
  logic [3:0]       code_q;
  logic [1:0]       result_q;
  logic [BAL_W-1:0] bal_q;
  logic [1:0]       tens;
  logic [4:0]       ones;
  logic [CW-1:0]    cnt_inc;
  logic             tmo, pay_ok;
  always_comb begin
    tens    = ITEM >= 5'd30 ? 2'd3 : ITEM >= 5'd20 ? 2'd2 : ITEM >= 5'd10 ? 2'd1 : 2'd0;
    ones    = ITEM - {tens, 3'b000} - {2'b00, tens, 1'b0};
    cnt_inc = cnt_q + CW'(cnt_q != '1);
    tmo     = cnt_q == CW'(RESP_TIMEOUT - 1);
    pay_ok  = !BAL_EN || bal_q >= BAL_W'(COST);
  end
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ones_q     <= '0;
      tens_q     <= '0;
      cost_q     <= '0;
      declined_q <= 1'b0;
      card_q     <= 1'b0;
      key_q      <= 1'b0;
      vt_q       <= 1'b0;
      door_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      code_q     <= '0;
      result_q   <= '0;
      bal_q      <= '0;
    end else begin
      done_q <= 1'b0;
      key_q  <= 1'b0;
      vt_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (BAL_EN && LOAD_BAL) bal_q <= BAL_IN;
          if (START) begin
            state_q <= CARD;
            busy_q  <= 1'b1;
            card_q  <= 1'b1;
            cnt_q   <= '0;
            ones_q  <= ones[3:0];
            tens_q  <= tens;
          end
        end
        CARD:
          if (cnt_q == CW'(KEY_GAP - 1)) begin
            state_q <= KEY1;
            key_q   <= 1'b1;
            code_q  <= ones_q;
          end else cnt_q <= cnt_inc;
        KEY1: state_q <= HOLD1;
        HOLD1: begin
          state_q <= KEY2;
          key_q   <= 1'b1;
          code_q  <= {2'b00, tens_q};
        end
        KEY2: state_q <= HOLD2;
        HOLD2: begin
          state_q <= WAIT_COST;
          code_q  <= '0;
          cnt_q   <= '0;
        end
        WAIT_COST:
          if (INVALID_SEL || (COST == 3'd0 && tmo)) begin
            state_q  <= FINISH;
            done_q   <= 1'b1;
            card_q   <= 1'b0;
            result_q <= INVALID_SEL ? 2'd1 : 2'd3;
          end else if (COST != 3'd0) begin
            // the payment decision is made here so VALID_TRAN is registered in the PAY cycle
            state_q    <= PAY;
            card_q     <= 1'b0;
            cost_q     <= COST;
            vt_q       <= pay_ok;
            declined_q <= !pay_ok;
          end else cnt_q <= cnt_inc;
        PAY: begin
          state_q <= WAIT_VEND;
          cnt_q   <= '0;
        end
        WAIT_VEND:
          if (VEND && !declined_q) begin
            state_q <= DOOR;
            door_q  <= 1'b1;
            cnt_q   <= '0;
            if (BAL_EN) bal_q <= bal_q - BAL_W'(cost_q);
          end else if (FAILED_TRAN || tmo) begin
            state_q  <= FINISH;
            done_q   <= 1'b1;
            result_q <= (FAILED_TRAN || declined_q) ? 2'd2 : 2'd3;
          end else cnt_q <= cnt_inc;
        DOOR:
          if (cnt_q == CW'(DOOR_HOLD - 1)) begin
            state_q  <= FINISH;
            door_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= 2'd0;
          end else cnt_q <= cnt_inc;
        FINISH: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign CARD_IN    = card_q;
  assign KEY_PRESS  = key_q;
  assign VALID_TRAN = vt_q;
  assign DOOR_OPEN  = door_q;
  assign ITEM_CODE  = code_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign RESULT     = result_q;
  assign BALANCE    = bal_q;
endmodule

// File: doc/vend_purchase_sequencer.md
# vend_purchase_sequencer

Customer-side transaction initiator for the vending machine controller. On a START pulse it inserts the card, keys a two-digit item code, waits for the machine to quote a cost or reject the selection, authorises payment against an internal card balance, and operates the delivery door. It then reports a result code. It sits opposite the vending machine on the CARD_IN/KEY_PRESS/VALID_TRAN/DOOR_OPEN interface. It serves as both the front-panel/card-terminal model and the bench stimulus agent.

## Interface
- KEY_GAP, default 2: cycles from CARD_IN rising to the first KEY_PRESS; legal range 1..3.
- DOOR_HOLD, default 2: cycles DOOR_OPEN is held high; legal range 1..4.
- RESP_TIMEOUT, default 16: cycles allowed for any machine response before the transaction is abandoned.
- BAL_W, default 8: width of the card balance.
- CLK  in  1  single clock; all logic is on the rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- START  in  1  one-cycle request; ignored while BUSY.
- ITEM  in  5  item number, 0..31; values above 19 are legal and deliberately provoke an invalid selection.
- LOAD_BAL  in  1  loads BAL_IN into the balance; ignored while BUSY.
- BAL_IN  in  BAL_W  balance load value.
- VEND, INVALID_SEL, FAILED_TRAN  in  1 each  machine status outputs.
- COST  in  3  machine cost quote; nonzero only while the machine holds a valid selection.
- CARD_IN, KEY_PRESS, VALID_TRAN, DOOR_OPEN  out  1 each  machine inputs.
- ITEM_CODE  out  4  digit presented with KEY_PRESS.
- BUSY  out  1  high from the cycle after START until the DONE cycle inclusive.
- DONE  out  1  one-cycle completion pulse.
- RESULT  out  2  encoding: 0 = vended, 1 = invalid selection, 2 = declined, 3 = timeout; valid when DONE is high and held until the next START.
- BALANCE  out  BAL_W  current card balance.

## Operation
- At START, latch ITEM. Compute ones = ITEM mod 10 and tens = ITEM / 10 (tens ≤ 3). BUSY rises.
- State machine states: IDLE, CARD, KEY1, HOLD1, KEY2, HOLD2, WAIT_COST, PAY, WAIT_VEND, DOOR, FINISH.
- CARD: CARD_IN=1. Wait KEY_GAP cycles, then go to KEY1.
- KEY1: KEY_PRESS=1, ITEM_CODE=ones. HOLD1: KEY_PRESS=0, ITEM_CODE still ones.
- KEY2: KEY_PRESS=1, ITEM_CODE=tens. HOLD2: ITEM_CODE still tens. Then go to WAIT_COST.
- ITEM_CODE is 0 outside KEY1 through HOLD2.
- WAIT_COST exits on the first of the following:
  - INVALID_SEL=1: drop CARD_IN, RESULT=1, go to FINISH.
  - COST≠0: capture the cost, go to PAY.
  - RESP_TIMEOUT cycles elapse: RESULT=3, go to FINISH.
- PAY, when BALANCE ≥ captured cost:
  - VALID_TRAN=1 for exactly one cycle.
  - CARD_IN drops in the same cycle, because the machine returns to idle and must not see the card still inserted.
  - Go to WAIT_VEND.
- PAY, when BALANCE < captured cost:
  - VALID_TRAN stays 0 and CARD_IN drops.
  - Wait in WAIT_VEND for FAILED_TRAN.
  - On FAILED_TRAN, or on timeout, set RESULT=2 and go to FINISH.
- WAIT_VEND on VEND=1:
  - BALANCE -= captured cost (unsigned; cannot underflow because the check already passed).
  - Go to DOOR.
  - If FAILED_TRAN=1 arrives instead, or the timeout expires: RESULT=2 or 3 respectively, go to FINISH.
- DOOR: DOOR_OPEN=1 for DOOR_HOLD cycles, then 0. RESULT=0, go to FINISH.
- FINISH: DONE=1 for one cycle, BUSY=0 next cycle, return to IDLE. CARD_IN, KEY_PRESS, VALID_TRAN and DOOR_OPEN are all 0 here.
- Timeout counter: restarts on entry to WAIT_COST and to WAIT_VEND; saturates, never wraps.
- Simultaneous events:
  - INVALID_SEL and COST≠0 in the same cycle: INVALID_SEL wins.
  - VEND and FAILED_TRAN in the same cycle: VEND wins.
  - START and LOAD_BAL in the same IDLE cycle: both take effect; the new balance is used for the check.
- Reset, including mid-transaction: all outputs 0, RESULT=0, BALANCE=0, state IDLE. The machine is expected to be reset alongside.

## Timing
- START sampled at edge t. CARD_IN=1 from cycle t+1.
- KEY_PRESS at cycles t+1+KEY_GAP and t+3+KEY_GAP.
- Earliest COST sample is t+5+KEY_GAP. VALID_TRAN follows one cycle after COST≠0 is seen.
- DOOR_OPEN rises the cycle after VEND=1.
- DONE comes one cycle after the final DOOR_OPEN cycle, or one cycle after the terminating event.
- All outputs are registered; none is combinational from inputs.

## Configuration
- VEND_SEQ_BALANCE_EN defined: balance register, LOAD_BAL, the PAY balance check and the VEND decrement are all present as described.
- VEND_SEQ_BALANCE_EN undefined:
  - BALANCE is tied to 0 and LOAD_BAL/BAL_IN are ignored.
  - PAY always asserts VALID_TRAN.
  - RESULT=2 occurs only on FAILED_TRAN.

## Test plan
- Load balance 10, ITEM=5; machine quotes COST=2, then VEND → keys 5 then 0, VALID_TRAN pulse, DOOR_OPEN 2 cycles, RESULT=0, BALANCE=8.
- ITEM=23; machine raises INVALID_SEL → ITEM_CODE 3 then 2, CARD_IN drops, no VALID_TRAN, RESULT=1, BALANCE unchanged.
- Balance 1, ITEM=17 (COST=5) → no VALID_TRAN; machine raises FAILED_TRAN; RESULT=2, BALANCE=1.
- Machine silent after the keys → DONE exactly RESP_TIMEOUT cycles after entering WAIT_COST, RESULT=3.
- RESET_N low during the DOOR state → all outputs 0 immediately; a START after release runs a clean transaction. A START while BUSY is ignored.
